maze_tx_checker: RTL

Stimulus and response endpoint for the 15×15 maze solver. It holds a software-loaded maze image and streams it serially to the solver on `in_valid`/`maze`. It then consumes the solver's result, either a back-traced path of coordinates or a single `maze_not_valid` pulse, and checks it against the stored maze and an expected-solvability flag. It sits opposite the solver on the same serial and path interfaces, on the test/BIST side of the design.

---
 rtl/maze_tx_if.sv | 23 ++
 rtl/maze_tx_checker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/maze_tx_if.sv
// Serial maze / solver-response bus between the tx checker and the 15x15 maze solver.
//   in_valid, maze          : serial maze image, checker -> solver
//   sol_valid, sol_not_valid: solver response strobes, solver -> checker
//   sol_x, sol_y            : solver path coordinate (column, row)
// master = checker side, slave = solver side.
interface maze_tx_if;
  logic       in_valid;
  logic       maze;
  logic       sol_valid;
  logic       sol_not_valid;
  logic [3:0] sol_x;
  logic [3:0] sol_y;

  modport master (
    output in_valid, maze,
    input  sol_valid, sol_not_valid, sol_x, sol_y
  );

  modport slave (
    input  in_valid, maze,
    output sol_valid, sol_not_valid, sol_x, sol_y
  );
endinterface

// File: rtl/maze_tx_checker.sv
// Stimulus/response endpoint for the 15x15 maze solver. Holds a software-loaded
// maze image, streams it row-major on bus.in_valid/bus.maze, then checks the
// solver's path (or maze_not_valid pulse) against the image and the expected
// solvability flag.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   load_valid/row/data   : write one 15-bit maze row (IDLE only; row 15 ignored)
//   start, exp_solvable   : begin a transaction; expected-solvable flag
//   bus (master)          : serial maze out, solver response in
//   busy, done, pass      : status; done is a one-cycle pulse
//   err_code              : first error seen (0 = none)
//   path_len              : number of response samples, saturating at 255
// Optional feature: define MAZE_TX_WALL_CHECK_EN to flag path samples on wall
// cells (error 6).
module maze_tx_checker #(
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [3:0]  load_row,
  input  logic [14:0] load_data,
  input  logic        start,
  input  logic        exp_solvable,
  maze_tx_if.master   bus,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  err_code,
  output logic [7:0]  path_len
);

  localparam int unsigned DIM    = 15;
  localparam int unsigned LAST   = DIM - 1;
  localparam int unsigned WCNT_W = 16;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

  state_t            state;
  logic [DIM-1:0]    mem [DIM];
  logic [3:0]        row, col;
  logic [WCNT_W-1:0] wcnt;
  logic              exp_q;
  logic              first_q;
  logic [3:0]        prev_x, prev_y;

  logic              col_wrap_c;
  logic [3:0]        nxt_row_c, nxt_col_c;
  logic              sample_c;
  logic [3:0]        dx_c, dy_c;
  logic [4:0]        dist_c;
  logic [2:0]        samp_err_c;
  logic [2:0]        end_err_c;
  logic [7:0]        len_inc_c;

  // Next serial cell, row-major.
  always_comb begin
    col_wrap_c = (col == 4'(LAST));
    nxt_col_c  = col_wrap_c ? 4'd0 : 4'(col + 4'd1);
    nxt_row_c  = (col_wrap_c && row != 4'(LAST)) ? 4'(row + 4'd1) : row;
  end

  assign sample_c  = (state == WAIT || state == RECV) && bus.sol_valid;
  assign len_inc_c = (path_len == 8'd255) ? 8'd255 : 8'(path_len + 8'd1);

  // Manhattan distance to the previous sample.
  always_comb begin
    dx_c   = (bus.sol_x >= prev_x) ? 4'(bus.sol_x - prev_x) : 4'(prev_x - bus.sol_x);
    dy_c   = (bus.sol_y >= prev_y) ? 4'(bus.sol_y - prev_y) : 4'(prev_y - bus.sol_y);
    dist_c = 5'(dx_c) + 5'(dy_c);
  end

`ifdef MAZE_TX_WALL_CHECK_EN
  logic cell_wall_c;
  // Off-grid coordinates can never be open cells.
  always_comb begin
    cell_wall_c = 1'b1;
    if (bus.sol_x < 4'(DIM) && bus.sol_y < 4'(DIM))
      cell_wall_c = mem[bus.sol_y][bus.sol_x];
  end
`endif

  // Error raised by the current response sample; lowest code wins within a sample.
  always_comb begin
    samp_err_c = 3'd0;
    if (exp_q) begin
      if (bus.sol_not_valid)
        samp_err_c = 3'd2;
      else if (first_q && (bus.sol_x != 4'd13 || bus.sol_y != 4'd13))
        samp_err_c = 3'd4;
      else if (!first_q && dist_c != 5'd1)
        samp_err_c = 3'd5;
`ifdef MAZE_TX_WALL_CHECK_EN
      else if (cell_wall_c)
        samp_err_c = 3'd6;
`endif
    end else if (!bus.sol_not_valid || !first_q) begin
      samp_err_c = 3'd3;
    end
  end

  // End-of-path check: prev_x/prev_y hold the last sample once sol_valid drops.
  assign end_err_c = (exp_q && (prev_x != 4'd1 || prev_y != 4'd1 || path_len > 8'd169))
                     ? 3'd7 : 3'd0;

  // Maze image storage; writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) mem[r] <= '0;
    end else if (state == IDLE && load_valid && load_row < 4'(DIM)) begin
      mem[load_row] <= load_data;
    end
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.in_valid <= 1'b0;
      bus.maze     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_code     <= 3'd0;
      path_len     <= 8'd0;
      row          <= 4'd0;
      col          <= 4'd0;
      wcnt         <= '0;
      exp_q        <= 1'b0;
      first_q      <= 1'b0;
      prev_x       <= 4'd0;
      prev_y       <= 4'd0;
    end else begin
      done <= 1'b0;

      if (sample_c) begin
        path_len <= len_inc_c;
        first_q  <= 1'b0;
        prev_x   <= bus.sol_x;
        prev_y   <= bus.sol_y;
        if (err_code == 3'd0) err_code <= samp_err_c;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state        <= SEND;
            busy         <= 1'b1;
            exp_q        <= exp_solvable;
            pass         <= 1'b0;
            err_code     <= 3'd0;
            path_len     <= 8'd0;
            row          <= 4'd0;
            col          <= 4'd0;
            bus.in_valid <= 1'b1;
            bus.maze     <= mem[0][0];
          end
        end
        SEND: begin
          if (row == 4'(LAST) && col == 4'(LAST)) begin
            state        <= WAIT;
            bus.in_valid <= 1'b0;
            bus.maze     <= 1'b0;
            wcnt         <= '0;
            first_q      <= 1'b1;
          end else begin
            row      <= nxt_row_c;
            col      <= nxt_col_c;
            bus.maze <= mem[nxt_row_c][nxt_col_c];
          end
        end
        WAIT: begin
          if (bus.sol_valid) begin
            state <= RECV;
          end else if (wcnt == WCNT_W'(TIMEOUT)) begin
            state    <= DONE;
            err_code <= 3'd1;
            pass     <= 1'b0;
            done     <= 1'b1;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        RECV: begin
          if (!bus.sol_valid) begin
            state <= DONE;
            done  <= 1'b1;
            if (err_code == 3'd0 && end_err_c != 3'd0) begin
              err_code <= end_err_c;
              pass     <= 1'b0;
            end else begin
              pass <= (err_code == 3'd0);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
